// File: rtl/f_fetch_unit.sv
// f_fetch_unit: MIPS fetch stage owning the PC, driving a synchronous IM and feeding the D register
module f_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_exc
);
  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]  r_fsm;
  logic [31:0] r_fetch_pc;
  logic        r_pend;
  logic [31:0] r_pend_pc;
  logic        w_run;
  logic [31:0] w_next;
  logic [31:0] w_addr;
  always_comb begin
    w_run   = r_fsm == RUN;
    w_next  = Redirect ? Redirect_PC : r_pend ? r_pend_pc : r_fetch_pc + 32'd4;
    // a stall re-issues the current address so the IM output stays stable
    w_addr  = Stall ? r_fetch_pc : w_next;
    im_addr = w_run ? {w_addr[31:2], 2'b00} : RESET_PC;
    F_valid = w_run;
    F_PC    = w_run ? r_fetch_pc : RESET_PC;
    F_exc   = w_run && (r_fetch_pc[1:0] != 2'b00 || r_fetch_pc < IM_LO || r_fetch_pc > IM_HI);
    F_instr = (w_run && !F_exc) ? im_rdata : 32'd0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm      <= BOOT;
      r_fetch_pc <= RESET_PC;
      r_pend     <= 1'b0;
      r_pend_pc  <= 32'd0;
    end else if (!w_run) begin
      r_fsm <= RUN;
    end else if (!Stall) begin
      r_fetch_pc <= w_next;
      r_pend     <= 1'b0;
    end else if (Redirect) begin
      r_pend    <= 1'b1;
      r_pend_pc <= Redirect_PC;
    end
  end
endmodule

// File: tb/tb_f_fetch_unit.sv
// tb_f_fetch_unit: scoreboarded random and directed checks of f_fetch_unit against a PC-level model
module tb_f_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFC;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        exc;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] Redirect_PC = 32'd0;
  logic [31:0] im_addr;
  logic [31:0] im_rdata = 32'd0;
  logic [31:0] F_PC;
  logic [31:0] F_instr;
  logic        F_valid;
  logic        F_exc;
  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  logic        booted = 1'b0;
  logic [31:0] pc = RESET_PC;
  logic [31:0] pend_q[$];
  f_fetch_unit dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect), .Redirect_PC(Redirect_PC),
    .im_addr(im_addr), .im_rdata(im_rdata), .F_PC(F_PC), .F_instr(F_instr),
    .F_valid(F_valid), .F_exc(F_exc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction
  always @(posedge clk) im_rdata <= mem_f(im_addr);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("F_valid", {31'd0, F_valid}, {31'd0, e.valid});
      chk("F_PC", F_PC, e.pc);
      chk("F_exc", {31'd0, F_exc}, {31'd0, e.exc});
      chk("F_instr", F_instr, e.instr);
      chk("im_addr", im_addr, e.addr);
    end
  end
  task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] rp);
    exp_t        e;
    logic [31:0] nxt;
    @(posedge clk);
    #1;
    reset = rst;
    Stall = st;
    Redirect = rd;
    Redirect_PC = rp;
    if (!rst) begin
      booted = 1'b0;
      pc = RESET_PC;
      pend_q.delete();
    end
    nxt = rd ? rp : (pend_q.size() > 0) ? pend_q[0] : pc + 32'd4;
    if (!booted) begin
      e = '{RESET_PC, RESET_PC, 32'd0, 1'b0, 1'b0};
    end else begin
      e.valid = 1'b1;
      e.pc = pc;
      e.exc = (pc % 4 != 0) || pc < IM_LO || pc > IM_HI;
      e.instr = e.exc ? 32'd0 : mem_f(pc & ~32'd3);
      e.addr = st ? (pc & ~32'd3) : (nxt & ~32'd3);
    end
    exp_q.push_back(e);
    if (rst) begin
      if (!booted) booted = 1'b1;
      else if (!st) begin
        pc = nxt;
        pend_q.delete();
      end else if (rd) begin
        pend_q.delete();
        pend_q.push_back(rp);
      end
    end
  endtask
  function automatic logic [31:0] rand_target();
    int k;
    k = $urandom_range(9);
    if (k < 6) return IM_LO + 32'($urandom_range(32'h0FFF)) * 4;
    if (k == 6) return IM_HI - 32'($urandom_range(3)) * 4;
    if (k == 7) return IM_LO + 32'($urandom_range(255)) * 4 + 32'($urandom_range(1, 3));
    if (k == 8) return 32'hFFFF_FFF8 + 32'($urandom_range(1)) * 4;
    return $urandom();
  endfunction
  initial begin
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h3100);
    step(1, 0, 0, 0);
    step(1, 1, 1, 32'h3200);
    step(1, 1, 1, 32'h3300);
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h3102);
    step(1, 0, 1, 32'h7000);
    step(1, 0, 1, 32'h6FF8);
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 1, 32'h3400);
    step(1, 1, 1, 32'h3500);
    step(0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    step(1, 0, 1, 32'hFFFF_FFFC);
    repeat (2) step(1, 0, 0, 0);
    repeat (600) begin
      logic rst;
      rst = $urandom_range(99) >= 2;
      step(rst, $urandom_range(99) < 30, $urandom_range(99) < 20, rand_target());
    end
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
